// File: rtl/spi_wb_sched.sv
// Round-robin scheduler that shares one simple_spi Wishbone slave between NUM_REQ requesters,
// sequencing the register accesses for a single polled byte transfer per grant.
module spi_wb_sched #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SS_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [2*NUM_REQ-1:0]         req_mode_i,
  input  logic [4*NUM_REQ-1:0]         req_div_i,
  input  logic [SS_WIDTH*NUM_REQ-1:0]  req_ss_i,
  input  logic [8*NUM_REQ-1:0]         req_tx_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic                         err_o,
  output logic [7:0]                   rx_data_o,
  output logic                         busy_o,
  output logic                         cyc_o,
  output logic                         stb_o,
  output logic                         we_o,
  output logic [2:0]                   adr_o,
  output logic [7:0]                   dat_o,
  input  logic [7:0]                   dat_i,
  input  logic                         ack_i
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    StIdle, StDis, StCfg, StExt, StSsOn, StTx, StPoll, StSsOff, StClr, StRx, StDone
  } state_e;

  state_e              state_q, state_d;
  logic                gap_q, gap_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          div_q, div_d;
  logic [SS_WIDTH-1:0] ss_q, ss_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          rd_q, rd_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic [7:0]          rx_q, rx_d;

  logic                found;
  logic [PW-1:0]       win;
  logic [7:0]          ss8;

  if (SS_WIDTH >= 8) begin : g_ss_trunc
    assign ss8 = ss_q[7:0];
  end else begin : g_ss_ext
    assign ss8 = {{(8 - SS_WIDTH){1'b0}}, ss_q};
  end

  // First requester at or after the pointer, then wrap to the lower indices.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req_i[i] && (PW'(i) >= ptr_q)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && req_i[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    mode_d  = mode_q;
    div_d   = div_q;
    ss_d    = ss_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    rx_d    = rx_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StDis;
          gap_d   = 1'b0;
          ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
          gnt_d   = '0;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == PW'(i)) begin
              gnt_d[i] = 1'b1;
              mode_d   = req_mode_i[2*i +: 2];
              div_d    = req_div_i[4*i +: 4];
              ss_d     = req_ss_i[SS_WIDTH*i +: SS_WIDTH];
              tx_d     = req_tx_i[8*i +: 8];
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
      default: begin
        if (!gap_q) begin
          if (ack_i) begin
            gap_d = 1'b1;
            rd_d  = dat_i;
            if (state_q == StPoll && !dat_i[7]) begin
              if (cnt_q < 16'(TIMEOUT)) cnt_d = cnt_q + 16'd1;
              if (cnt_q + 16'd1 >= 16'(TIMEOUT)) abort_d = 1'b1;
            end
          end
        end else begin
          gap_d = 1'b0;
          case (state_q)
            StDis:   state_d = StCfg;
            StCfg:   state_d = StExt;
            StExt:   state_d = StSsOn;
            StSsOn:  state_d = StTx;
            StTx:    state_d = StPoll;
            StPoll:  state_d = (rd_q[7] || abort_q) ? StSsOff : StPoll;
            StSsOff: state_d = StClr;
            StClr:   state_d = StRx;
            StRx: begin
              state_d = StDone;
              rx_d    = abort_q ? 8'h00 : rd_q;
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    we_o  = 1'b0;
    adr_o = 3'd0;
    dat_o = 8'h00;
    case (state_q)
      StDis:   begin we_o = 1'b1; adr_o = 3'd0; dat_o = 8'h00; end
      StCfg:   begin we_o = 1'b1; adr_o = 3'd0; dat_o = {4'b0101, mode_q, div_q[1:0]}; end
      StExt:   begin we_o = 1'b1; adr_o = 3'd3; dat_o = {6'b0, div_q[3:2]}; end
      StSsOn:  begin we_o = 1'b1; adr_o = 3'd4; dat_o = ss8; end
      StTx:    begin we_o = 1'b1; adr_o = 3'd2; dat_o = tx_q; end
      StPoll:  begin we_o = 1'b0; adr_o = 3'd1; end
      StSsOff: begin we_o = 1'b1; adr_o = 3'd4; dat_o = 8'h00; end
      StClr:   begin we_o = 1'b1; adr_o = 3'd1; dat_o = 8'hC0; end
      StRx:    begin we_o = 1'b0; adr_o = 3'd2; end
      default: ;
    endcase
  end

  assign cyc_o     = (state_q != StIdle) && (state_q != StDone) && !gap_q;
  assign stb_o     = cyc_o;
  assign gnt_o     = gnt_q;
  assign done_o    = (state_q == StDone) ? gnt_q : '0;
  assign err_o     = (state_q == StDone) && abort_q;
  assign busy_o    = (state_q != StIdle);
  assign rx_data_o = rx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gap_q   <= 1'b0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      mode_q  <= '0;
      div_q   <= '0;
      ss_q    <= '0;
      tx_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      ss_q    <= ss_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      rx_q    <= rx_d;
    end
  end

endmodule
